// File: rtl/fir_transposed_param.sv
// Transposed-form FIR with runtime-loadable coefficients held in a shadow/active double bank.
// The output is rounded half-up, shifted right by SHIFT and saturated to OUT_W bits.
module fir_transposed_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 27,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       flush,
  input  logic                       coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  input  logic                       coef_commit,
  output logic                       out_valid,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_sat
);

  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int EW    = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;
  localparam int RB    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [AW:0] TAPS_L = (AW + 1)'(TAPS);

  logic signed [COEF_W-1:0] r_shadow [TAPS];
  logic signed [COEF_W-1:0] r_active [TAPS];
  logic signed [ACC_W-1:0]  r_p [1:TAPS-1];
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out_data;
  logic                     r_out_sat;

  logic signed [ACC_W-1:0]  w_x;
  logic signed [ACC_W-1:0]  w_coef [TAPS];
  logic signed [ACC_W-1:0]  w_prod [TAPS];
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [EW-1:0]     w_acc_ext;
  logic signed [EW-1:0]     w_bias;
  logic signed [EW-1:0]     w_rnd;
  logic signed [EW-1:0]     w_max;
  logic signed [EW-1:0]     w_min;
  logic signed [OUT_W-1:0]  w_out;
  logic                     w_sat;
  logic                     w_wr_hit;

  // Handshake: there is no ready; every in_valid sample is accepted, and out_valid
  // pulses for exactly one cycle on the edge after the sample was taken.
  assign w_x      = ACC_W'(in_data);
  assign w_wr_hit = coef_wr_en && ({1'b0, coef_addr} < TAPS_L);

  // Products are formed at full accumulator width so no stage can wrap.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_coef[k] = ACC_W'(r_active[k]);
      w_prod[k] = w_coef[k] * w_x;
    end
  end

  // A flush in the same cycle as a sample treats the old partial sums as zero.
  assign w_acc = (flush ? ACC_W'(0) : r_p[1]) + w_prod[0];

  always_comb begin
    w_acc_ext = EW'(w_acc);
    w_bias    = '0;
    if (SHIFT > 0) w_bias[RB] = 1'b1;
    w_rnd = (w_acc_ext + w_bias) >>> SHIFT;
    w_max = {{(EW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    w_min = ~w_max;
    w_out = w_rnd[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_rnd > w_max) begin
      w_out = w_max[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_rnd < w_min) begin
      w_out = w_min[OUT_W-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
      for (int k = 1; k < TAPS; k++) r_p[k] <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      // Commit copies the shadow as it was before this edge's write.
      if (w_wr_hit) r_shadow[coef_addr] <= coef_wdata;
      if (coef_commit) begin
        for (int k = 0; k < TAPS; k++) r_active[k] <= r_shadow[k];
      end
      if (in_valid) begin
        r_p[TAPS-1] <= w_prod[TAPS-1];
        for (int k = 1; k < TAPS - 1; k++)
          r_p[k] <= (flush ? ACC_W'(0) : r_p[k+1]) + w_prod[k];
      end else if (flush) begin
        for (int k = 1; k < TAPS; k++) r_p[k] <= '0;
      end
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out_data <= w_out;
        r_out_sat  <= w_sat;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_fir_transposed_param.sv
// Directed bench for fir_transposed_param: default, 16-bit-output and SHIFT=1 instances share stimulus.
module tb_fir_transposed_param;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               flush;
  logic               coef_wr_en;
  logic [4:0]         coef_addr;
  logic signed [15:0] coef_wdata;
  logic               coef_commit;

  logic               a_v, s_v, r_v;
  logic signed [31:0] a_d, r_d;
  logic signed [15:0] s_d;
  logic               a_s, s_s, r_s;

  int total = 0;
  int bad   = 0;
  int h_tab [27];

  typedef struct {
    logic               v;
    logic               fl;
    logic signed [15:0] x;
    logic               ev;
    logic signed [31:0] ed;
    logic               es;
  } vec_t;
  vec_t vecs [$];

  fir_transposed_param dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .out_valid(a_v), .out_data(a_d), .out_sat(a_s)
  );

  fir_transposed_param #(.OUT_W(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .out_valid(s_v), .out_data(s_d), .out_sat(s_s)
  );

  fir_transposed_param #(.SHIFT(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .out_valid(r_v), .out_data(r_d), .out_sat(r_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_a(input string name, input logic ev, input int ed, input logic es);
    check({name, " valid"}, a_v, ev);
    check({name, " data"}, a_d, ed);
    check({name, " sat"}, a_s, es);
  endtask

  // driver tasks
  task automatic idle();
    in_valid = 1'b0; in_data = '0; flush = 1'b0;
    coef_wr_en = 1'b0; coef_addr = '0; coef_wdata = '0; coef_commit = 1'b0;
  endtask

  task automatic sample(input logic fl, input int x);
    in_valid = 1'b1; flush = fl; in_data = 16'(x);
    tick();
    in_valid = 1'b0; flush = 1'b0; in_data = '0;
  endtask

  task automatic load_tab();
    for (int k = 0; k < 27; k++) begin
      coef_wr_en = 1'b1; coef_addr = 5'(k); coef_wdata = 16'(h_tab[k]);
      tick();
    end
    coef_wr_en = 1'b0;
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
  endtask

  task automatic add_vec(input logic v, input logic fl, input int x, input logic ev, input int ed, input logic es);
    vec_t r;
    r.v = v; r.fl = fl; r.x = 16'(x); r.ev = ev; r.ed = ed; r.es = es;
    vecs.push_back(r);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      in_valid = vecs[i].v; flush = vecs[i].fl; in_data = vecs[i].x;
      tick();
      check_a($sformatf("%s[%0d]", tag, i), vecs[i].ev, vecs[i].ed, vecs[i].es);
    end
    vecs.delete();
    idle();
  endtask

  initial begin
    int prev;
    idle();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 16'sd5;
    tick(); tick();
    idle();
    check_a("reset", 1'b0, 0, 1'b0);
    check("reset s_data", s_d, 0);
    check("reset r_valid", r_v, 0);
    rst_n = 1'b0;

    // impulse response with h[k]=k+1
    for (int k = 0; k < 27; k++) h_tab[k] = k + 1;
    load_tab();
    check_a("load idle", 1'b0, 0, 1'b0);
    for (int i = 0; i < 30; i++) add_vec(1'b1, 1'b0, (i == 0) ? 1 : 0, 1'b1, (i < 27) ? i + 1 : 0, 1'b0);
    run_vecs("impulse");

    // same impulse with idle gaps of 0..2 cycles between samples
    prev = 0;
    for (int i = 0; i < 29; i++) begin
      if (i > 0)
        for (int g = 0; g < i % 3; g++) add_vec(1'b0, 1'b0, 7, 1'b0, prev, 1'b0);
      prev = (i < 27) ? i + 1 : 0;
      add_vec(1'b1, 1'b0, (i == 0) ? 1 : 0, 1'b1, prev, 1'b0);
    end
    run_vecs("gaps");

    // step response with h=1, then a shadow write and a mid-stream commit
    for (int k = 0; k < 27; k++) h_tab[k] = 1;
    load_tab();
    for (int i = 0; i < 30; i++) add_vec(1'b1, 1'b0, 1, 1'b1, (i < 27) ? i + 1 : 27, 1'b0);
    run_vecs("step");
    coef_wr_en = 1'b1; coef_addr = 5'd0; coef_wdata = 16'sd10;
    tick();
    idle();
    check_a("shadow write hold", 1'b0, 27, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample(1'b0, 1);
      check_a($sformatf("shadow only[%0d]", i), 1'b1, 27, 1'b0);
    end
    coef_commit = 1'b1; coef_wr_en = 1'b1; coef_addr = 5'd1; coef_wdata = 16'sd5;
    sample(1'b0, 1);
    idle();
    check_a("commit cycle old bank", 1'b1, 27, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample(1'b0, 1);
      check_a($sformatf("after commit[%0d]", i), 1'b1, 36, 1'b0);
    end

    // flush and reset mid-stream
    for (int k = 0; k < 27; k++) h_tab[k] = k + 1;
    load_tab();
    flush = 1'b1;
    tick();
    idle();
    check_a("flush idle hold", 1'b0, 36, 1'b0);
    for (int i = 0; i < 5; i++) add_vec(1'b1, 1'b0, (i == 0) ? 1 : 0, 1'b1, i + 1, 1'b0);
    add_vec(1'b1, 1'b1, 0, 1'b1, 0, 1'b0);
    add_vec(1'b1, 1'b0, 0, 1'b1, 0, 1'b0);
    add_vec(1'b1, 1'b0, 0, 1'b1, 0, 1'b0);
    add_vec(1'b1, 1'b1, 2, 1'b1, 2, 1'b0);
    add_vec(1'b1, 1'b0, 0, 1'b1, 4, 1'b0);
    add_vec(1'b1, 1'b0, 0, 1'b1, 6, 1'b0);
    run_vecs("flush");
    rst_n = 1'b1;
    sample(1'b0, 1);
    check_a("reset mid-stream", 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    sample(1'b0, 1);
    check_a("after reset h=0", 1'b1, 0, 1'b0);
    coef_commit = 1'b1;
    tick();
    idle();
    sample(1'b0, 1);
    check_a("shadow cleared by reset", 1'b1, 0, 1'b0);

    // saturation on the 16-bit output instance
    for (int k = 0; k < 27; k++) h_tab[k] = 32767;
    load_tab();
    sample(1'b0, 32767);
    check("sat pos data", s_d, 32767);
    check("sat pos flag", s_s, 1);
    check("sat pos valid", s_v, 1);
    check_a("wide no sat pos", 1'b1, 1073676289, 1'b0);
    tick();
    check("sat hold valid", s_v, 0);
    check("sat hold flag", s_s, 1);
    check("sat hold data", s_d, 32767);
    sample(1'b1, -32768);
    check("sat neg data", s_d, -32768);
    check("sat neg flag", s_s, 1);
    check_a("wide no sat neg", 1'b1, -1073709056, 1'b0);
    for (int k = 0; k < 27; k++) h_tab[k] = (k == 0) ? 1 : 0;
    load_tab();
    sample(1'b1, 5);
    check("unsat data", s_d, 5);
    check("unsat flag", s_s, 0);
    check("round 5", r_d, 3);

    // rounding on the SHIFT=1 instance
    sample(1'b0, 3);
    check("round 3", r_d, 2);
    check("round 3 valid", r_v, 1);
    check("shift0 3", a_d, 3);
    sample(1'b0, -3);
    check("round -3", r_d, -1);
    check("round -3 sat", r_s, 0);
    sample(1'b0, 2);
    check("round 2", r_d, 1);
    tick();
    check("round idle valid", r_v, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
